// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair (piso_tx and sipo).
package serdes_pkg;

   // Bit order on the serial link; both ends of a link must agree.
   localparam int unsigned SHIFT_LSB_FIRST = 0;
   localparam int unsigned SHIFT_MSB_FIRST = 1;

   // Transmit/receive sequencing states.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage : serdes_pkg

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-entry holding register.
// Words stream back-to-back with no gap so the downstream sipo stays frame aligned.
// The serial outputs are registered from the current shift state, so they trail
// the internal state by one cycle: accept at edge t, transfer at t+1, first bit after t+2.
module piso_tx
   import serdes_pkg::*;
#(
   parameter int unsigned SIZE      = 8,
   parameter int unsigned SHIFT_DIR = SHIFT_LSB_FIRST
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SIZE-1:0] data_in,
   input  logic            data_valid,
   output logic            data_ready,
   output logic            ser_out,
   output logic            ser_en,
   output logic            busy,
   output logic            done
);

   localparam int unsigned    CNT_W    = $clog2(SIZE);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SIZE-1:0]   shift_reg_q, shift_reg_d;
   logic [SIZE-1:0]   hold_reg_q, hold_reg_d;
   logic              hold_full_q, hold_full_d;
   logic              data_ready_q, data_ready_d;
   logic              ser_out_q, ser_out_d;
   logic              ser_en_q, ser_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              last_bit;
   logic              accept;
   logic              transfer;
   logic              cur_bit;

   // State, datapath and output registers; reset drops any in-flight word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_reg_q  <= '0;
         hold_reg_q   <= '0;
         hold_full_q  <= 1'b0;
         data_ready_q <= 1'b1;
         ser_out_q    <= 1'b0;
         ser_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_reg_q  <= shift_reg_d;
         hold_reg_q   <= hold_reg_d;
         hold_full_q  <= hold_full_d;
         data_ready_q <= data_ready_d;
         ser_out_q    <= ser_out_d;
         ser_en_q     <= ser_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next-state, holding-register handshake and serial output computation.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_reg_d = shift_reg_q;
      hold_reg_d  = hold_reg_q;
      hold_full_d = hold_full_q;

      last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
      accept   = data_valid && !hold_full_q;
      transfer = hold_full_q && ((state_q == IDLE) || last_bit);
      cur_bit  = (SHIFT_DIR == SHIFT_MSB_FIRST) ? shift_reg_q[SIZE-1] : shift_reg_q[0];

      ser_en_d  = (state_q == SHIFT);
      busy_d    = (state_q == SHIFT);
      done_d    = last_bit;
      ser_out_d = (state_q == SHIFT) ? cur_bit : 1'b0;

      case (state_q)
         IDLE: begin
            if (transfer) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               bit_cnt_d = '0;
               if (!transfer) begin
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
         end
      endcase

      // The next bit to present always sits at the outgoing end of shift_reg.
      if (transfer) begin
         shift_reg_d = hold_reg_q;
         hold_full_d = 1'b0;
      end else if (state_q == SHIFT) begin
         if (SHIFT_DIR == SHIFT_MSB_FIRST) begin
            shift_reg_d = shift_reg_q << 1;
         end else begin
            shift_reg_d = shift_reg_q >> 1;
         end
      end

      // Accept and transfer are mutually exclusive on hold_full_q.
      if (accept) begin
         hold_reg_d  = data_in;
         hold_full_d = 1'b1;
      end

      data_ready_d = !hold_full_d;
   end

   assign data_ready = data_ready_q;
   assign ser_out    = ser_out_q;
   assign ser_en     = ser_en_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (8-bit LSB-first, 8-bit MSB-first, 5-bit LSB-first)
// checked every cycle against a timeline model of when each accepted word is on the wire.
module tb_piso_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic go    = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned SZ  = (g == 2) ? 5 : 8;
      localparam int unsigned DIR = (g == 1) ? 1 : 0;
      localparam int          SZI = SZ;

      logic [SZ-1:0] data_in    = '0;
      logic          data_valid = 1'b0;
      logic          data_ready, ser_out, ser_en, busy, done;
      bit            ph1 = 1'b0;
      bit            ph2 = 1'b0;

      piso_tx #(.SIZE(SZ), .SHIFT_DIR(DIR)) u_dut (
         .clk        (clk),
         .reset      (rst_n),
         .data_in    (data_in),
         .data_valid (data_valid),
         .data_ready (data_ready),
         .ser_out    (ser_out),
         .ser_en     (ser_en),
         .busy       (busy),
         .done       (done)
      );

      // Reference model: each accepted word owns the output window [start, start+SZ).
      int            cyc = 0;
      int            last_start = -1000;
      int            s_q[$];
      logic [SZ-1:0] w_q[$];
      logic [SZ-1:0] rx = '0;
      logic          exp_en, exp_bit, exp_done, exp_rdy;
      int            idx, t_acc, s_new;

      always @(posedge clk) cyc <= cyc + 1;

      always @(negedge clk) begin
         if (!rst_n) begin
            s_q.delete();
            w_q.delete();
            last_start = -1000;
            rx = '0;
            tb_check($sformatf("i%0d_rst_ser_en", g), 32'(ser_en), 32'd0);
            tb_check($sformatf("i%0d_rst_ser_out", g), 32'(ser_out), 32'd0);
            tb_check($sformatf("i%0d_rst_busy", g), 32'(busy), 32'd0);
            tb_check($sformatf("i%0d_rst_done", g), 32'(done), 32'd0);
            tb_check($sformatf("i%0d_rst_ready", g), 32'(data_ready), 32'd1);
         end else begin
            while (s_q.size() > 0 && s_q[0] + SZI <= cyc) begin
               void'(s_q.pop_front());
               void'(w_q.pop_front());
            end
            exp_en = 1'b0; exp_bit = 1'b0; exp_done = 1'b0; idx = 0;
            if (s_q.size() > 0 && s_q[0] <= cyc) begin
               idx      = cyc - s_q[0];
               exp_en   = 1'b1;
               exp_bit  = (DIR == 1) ? w_q[0][SZI-1-idx] : w_q[0][idx];
               exp_done = (idx == SZI - 1);
            end
            // Holding register is occupied until the edge before its word starts.
            exp_rdy = 1'b1;
            foreach (s_q[k]) if (s_q[k] - 1 > cyc) exp_rdy = 1'b0;

            tb_check($sformatf("i%0d_ser_en", g), 32'(ser_en), 32'(exp_en));
            tb_check($sformatf("i%0d_ser_out", g), 32'(ser_out), 32'(exp_bit));
            tb_check($sformatf("i%0d_busy", g), 32'(busy), 32'(exp_en));
            tb_check($sformatf("i%0d_done", g), 32'(done), 32'(exp_done));
            tb_check($sformatf("i%0d_ready", g), 32'(data_ready), 32'(exp_rdy));

            // Deserializer view of the link: rebuild the word from observed bits.
            if (exp_en) begin
               if (DIR == 1) rx = {rx[SZ-2:0], ser_out};
               else          rx = {ser_out, rx[SZ-1:1]};
               if (exp_done) tb_check($sformatf("i%0d_sipo_word", g), 32'(rx), 32'(w_q[0]));
            end

            if (data_valid && exp_rdy) begin
               t_acc = cyc + 1;
               s_new = (t_acc + 2 > last_start + SZI) ? t_acc + 2 : last_start + SZI;
               s_q.push_back(s_new);
               w_q.push_back(data_in);
               last_start = s_new;
            end
         end
      end

      // Present one word and hold it (optionally scrambling data_in) until taken.
      task automatic send(input logic [SZ-1:0] w, input bit scramble);
         bit ok;
         ok = 1'b0;
         data_in    = w;
         data_valid = 1'b1;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_ready) begin
               ok = 1'b1;
               break;
            end
            @(posedge clk); #1;
            if (scramble) data_in = SZ'($urandom);
         end
         tb_check($sformatf("i%0d_send_taken", g), 32'(ok), 32'd1);
         @(posedge clk); #1;
      endtask

      task automatic idle(input int n);
         data_valid = 1'b0;
         repeat (n) @(posedge clk);
         #1;
      endtask

      initial begin : drive
         for (int i = 0; i < 100 && !rst_n; i++) @(posedge clk);
         #1;
         idle(2);
         send(SZ'((g == 2) ? 32'h13 : 32'hB4), 1'b0);
         idle(SZI + 6);
         send(SZ'(32'h11), 1'b0);
         send(SZ'(32'h22), 1'b0);
         send(SZ'(32'h33), 1'b0);
         idle(3 * SZI);
         for (int i = 0; i < 3; i++) send(SZ'($urandom), 1'b1);
         idle(2 * SZI);
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(SZ + 3, 1)));
            send(SZ'($urandom), 1'($urandom_range(1, 0)));
         end
         idle(2 * SZI + 4);
         ph1 = 1'b1;
         for (int i = 0; i < 5000 && !go; i++) @(posedge clk);
         #1;
         send('1, 1'b0);
         idle(0);
         for (int i = 0; i < 200 && rst_n; i++) @(posedge clk);
         for (int i = 0; i < 200 && !rst_n; i++) @(posedge clk);
         #1;
         send(SZ'(32'h5A), 1'b0);
         idle(2 * SZI + 4);
         ph2 = 1'b1;
      end
   end

   initial begin : main
      int  nb;
      bit  all_done;
      repeat (3) @(posedge clk);
      #1;
      tb_check("reset_ready", 32'(g_dut[0].data_ready), 32'd1);
      tb_check("reset_ser_en", 32'(g_dut[0].ser_en), 32'd0);
      rst_n = 1'b1;

      all_done = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         all_done = g_dut[0].ph1 && g_dut[1].ph1 && g_dut[2].ph1;
         if (all_done) break;
         @(posedge clk);
      end
      tb_check("phase1_complete", 32'(all_done), 32'd1);

      // Reset in the middle of an all-ones word on the 8-bit LSB-first instance.
      @(posedge clk); #1;
      go = 1'b1;
      nb = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (g_dut[0].ser_en) nb++;
         if (nb == 4) break;
      end
      @(posedge clk); #2;
      tb_check("mid_word_en", 32'(g_dut[0].ser_en), 32'd1);
      tb_check("mid_word_out", 32'(g_dut[0].ser_out), 32'd1);
      rst_n = 1'b0;
      #1;
      tb_check("async_rst_ser_en", 32'(g_dut[0].ser_en), 32'd0);
      tb_check("async_rst_ser_out", 32'(g_dut[0].ser_out), 32'd0);
      tb_check("async_rst_busy", 32'(g_dut[0].busy), 32'd0);
      tb_check("async_rst_done", 32'(g_dut[0].done), 32'd0);
      tb_check("async_rst_ready", 32'(g_dut[0].data_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      all_done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         all_done = g_dut[0].ph2 && g_dut[1].ph2 && g_dut[2].ph2;
         if (all_done) break;
         @(posedge clk);
      end
      tb_check("phase2_complete", 32'(all_done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_piso_tx
